gray_conv_stream: RTL and testbench

- Streaming, pipelined converter between binary and Gray code. WIDTH and pipeline depth are parametrised.
- Mode is selected per beat. Valid/ready handshake on both sides, with full backpressure.
- Adjacency checker flags Gray sequences that are not unit-distance (more or fewer than one bit changed).
- Sits between counter/pointer producers (e.g. async FIFO pointer logic) and consumers that need registered, flow-controlled code conversion.

---
 rtl/gray_conv_stream.sv | 140 ++++++++++++++
 tb/tb_gray_conv_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_stream.sv
`default_nettype none
// ============================================================================
// Module   : gray_conv_stream
// Purpose  : pipelined binary<->Gray converter, valid/ready, adjacency checker
// Revision : 1.0  initial release
// ============================================================================
module gray_conv_stream #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_adj_err,
    output logic [15:0]      err_cnt
);
    localparam logic [15:0]      c_CNT_MAX = 16'hFFFF;
    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES-1:0] r_mode;
    logic [STAGES-1:0] r_adj;

    logic [STAGES-1:0] w_take;
    logic [STAGES-1:0] w_src_valid;
    logic [WIDTH-1:0]  w_src_data [STAGES];
    logic [STAGES-1:0] w_src_mode;
    logic [STAGES-1:0] w_src_adj;

    logic [WIDTH-1:0]  w_b2g;
    logic [WIDTH-1:0]  w_g2b;
    logic [WIDTH-1:0]  w_conv;
    logic [WIDTH-1:0]  w_gray;
    logic [WIDTH-1:0]  w_diff;
    logic              w_onehot;
    logic              w_adj_err;
    logic              w_accept;

    logic [WIDTH-1:0]  r_prev_gray;
    logic              r_prev_mode;
    logic              r_hist_valid;
    logic [15:0]       r_err_cnt;

    always_comb begin
        w_b2g          = in_data ^ (in_data >> 1);
        w_g2b          = '0;
        w_g2b[WIDTH-1] = in_data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_g2b[i] = w_g2b[i+1] ^ in_data[i];
        end
    end

    assign w_conv = in_mode ? w_g2b : w_b2g;
    // For binary input the Gray word is the converted value itself
    assign w_gray = in_mode ? in_data : w_b2g;

    // Exactly one bit differs: non-zero and a power of two
    assign w_diff    = w_gray ^ r_prev_gray;
    assign w_onehot  = (w_diff != '0) && ((w_diff & (w_diff - c_ONE)) == '0);
    assign w_adj_err = r_hist_valid && (in_mode == r_prev_mode) && !w_onehot;

    // A slice can take a new beat if empty or if its own beat moves on this cycle
    always_comb begin
        w_take           = '0;
        w_take[STAGES-1] = !r_valid[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_take[k] = !r_valid[k] || w_take[k+1];
        end
    end

    assign in_ready = rstn && w_take[0];
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_src_valid[0] = w_accept;
        w_src_data[0]  = w_conv;
        w_src_mode[0]  = in_mode;
        w_src_adj[0]   = w_adj_err;
        for (int k = 1; k < STAGES; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_mode[k]  = r_mode[k-1];
            w_src_adj[k]   = r_adj[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= '0;
            r_mode  <= '0;
            r_adj   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_take[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_src_data[k];
                        r_mode[k] <= w_src_mode[k];
                        r_adj[k]  <= w_src_adj[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_prev_gray  <= '0;
            r_prev_mode  <= 1'b0;
            r_hist_valid <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_accept) begin
            r_prev_gray  <= w_gray;
            r_prev_mode  <= in_mode;
            r_hist_valid <= 1'b1;
            if (w_adj_err && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign out_valid   = r_valid[STAGES-1];
    assign out_data    = r_data[STAGES-1];
    assign out_mode    = r_mode[STAGES-1];
    assign out_adj_err = r_adj[STAGES-1];
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_stream.sv
`default_nettype none
// Bench for gray_conv_stream: directed checks on an 8-bit/2-stage instance and
// randomized comparison against a reference model on 16-bit 1- and 4-stage instances.
module tb_gray_conv_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // 8-bit, 2-stage instance for directed tests
    logic        a_in_valid, a_in_ready, a_in_mode;
    logic        a_out_valid, a_out_ready, a_out_mode, a_out_adj_err;
    logic [7:0]  a_in_data, a_out_data;
    logic [15:0] a_err_cnt;

    gray_conv_stream #(.WIDTH(8), .STAGES(2)) u_a (
        .clk(clk), .rstn(rstn),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_mode(a_out_mode), .out_adj_err(a_out_adj_err), .err_cnt(a_err_cnt)
    );

    // 16-bit instances with 1 and 4 stages, sharing one random stimulus
    logic        rnd_in_valid, rnd_in_mode, rnd_out_ready;
    logic [15:0] rnd_in_data;
    logic [1:0]  rnd_in_ready, rnd_out_valid, rnd_out_mode, rnd_out_adj;
    logic [15:0] rnd_out_data [2];
    logic [15:0] rnd_err_cnt [2];

    gray_conv_stream #(.WIDTH(16), .STAGES(1)) u_s1 (
        .clk(clk), .rstn(rstn),
        .in_valid(rnd_in_valid), .in_ready(rnd_in_ready[0]), .in_data(rnd_in_data), .in_mode(rnd_in_mode),
        .out_valid(rnd_out_valid[0]), .out_ready(rnd_out_ready), .out_data(rnd_out_data[0]),
        .out_mode(rnd_out_mode[0]), .out_adj_err(rnd_out_adj[0]), .err_cnt(rnd_err_cnt[0])
    );

    gray_conv_stream #(.WIDTH(16), .STAGES(4)) u_s4 (
        .clk(clk), .rstn(rstn),
        .in_valid(rnd_in_valid), .in_ready(rnd_in_ready[1]), .in_data(rnd_in_data), .in_mode(rnd_in_mode),
        .out_valid(rnd_out_valid[1]), .out_ready(rnd_out_ready), .out_data(rnd_out_data[1]),
        .out_mode(rnd_out_mode[1]), .out_adj_err(rnd_out_adj[1]), .err_cnt(rnd_err_cnt[1])
    );

    // Reference model state: expected beats in acceptance order, per instance
    logic [15:0] exp_data [2][1024];
    logic        exp_mode [2][1024];
    logic        exp_err  [2][1024];
    int          exp_cyc  [2][1024];
    int          wr [2];
    int          rd [2];
    logic        hv [2];
    logic        pm [2];
    logic [15:0] pg [2];
    int          cnt [2];

    function automatic logic [15:0] to_gray(input logic [15:0] b);
        return b ^ (b / 16'd2);
    endfunction

    // Binary bit i is the parity of all Gray bits at or above i
    function automatic logic [15:0] to_bin(input logic [15:0] g);
        logic [15:0] b = '0;
        for (int s = 0; s < 16; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            wr[id] = 0; rd[id] = 0; hv[id] = 1'b0; pm[id] = 1'b0; pg[id] = '0; cnt[id] = 0;
        end
    endtask

    task automatic model_accept(input int id);
        logic [15:0] g;
        logic        e;
        int          slot;
        g    = rnd_in_mode ? rnd_in_data : to_gray(rnd_in_data);
        e    = hv[id] && (pm[id] == rnd_in_mode) && ($countones(g ^ pg[id]) != 1);
        slot = wr[id] % 1024;
        exp_data[id][slot] = rnd_in_mode ? to_bin(rnd_in_data) : to_gray(rnd_in_data);
        exp_mode[id][slot] = rnd_in_mode;
        exp_err[id][slot]  = e;
        exp_cyc[id][slot]  = cyc;
        wr[id]++;
        hv[id] = 1'b1; pm[id] = rnd_in_mode; pg[id] = g;
        if (e && cnt[id] < 65535) cnt[id]++;
    endtask

    // phase 0: always-ready with latency check, 1: random backpressure, 2: drain
    task automatic rnd_cycle(input int phase);
        int stg, occ, slot;
        @(negedge clk);
        rnd_out_ready = (phase == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        rnd_in_valid  = (phase == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) rnd_in_mode = ~rnd_in_mode;
        case ($urandom_range(0, 2))
            0: rnd_in_data = 16'($urandom);
            1: rnd_in_data = rnd_in_mode ? (rnd_in_data ^ (16'h0001 << $urandom_range(0, 15)))
                                         : 16'(rnd_in_data + 16'd1);
            default: rnd_in_data = rnd_in_data;
        endcase
        #1;
        for (int id = 0; id < 2; id++) begin
            stg = (id == 0) ? 1 : 4;
            occ = wr[id] - rd[id];
            chk($sformatf("s%0d/in_ready", stg), rnd_in_ready[id], (occ < stg) || rnd_out_ready);
            if (rnd_out_valid[id] && rnd_out_ready) begin
                chk($sformatf("s%0d/beat_expected", stg), occ > 0, 1'b1);
                if (occ > 0) begin
                    slot = rd[id] % 1024;
                    chk($sformatf("s%0d/out_data", stg), rnd_out_data[id], exp_data[id][slot]);
                    chk($sformatf("s%0d/out_mode", stg), rnd_out_mode[id], exp_mode[id][slot]);
                    chk($sformatf("s%0d/out_adj_err", stg), rnd_out_adj[id], exp_err[id][slot]);
                    if (phase == 0)
                        chk($sformatf("s%0d/latency", stg), cyc - exp_cyc[id][slot], stg);
                    rd[id]++;
                end
            end
            chk($sformatf("s%0d/err_cnt", stg), rnd_err_cnt[id], cnt[id]);
            if (rnd_in_valid && rnd_in_ready[id]) model_accept(id);
        end
        @(posedge clk);
        cyc++;
    endtask

    // Single beat into an empty 2-stage pipe with out_ready high
    task automatic a_beat(input logic [7:0] d, input logic m, input logic [7:0] ed,
                          input logic ee, input string tag);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
        #1 chk({tag, "/in_ready"}, a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk({tag, "/not_yet"}, a_out_valid, 1'b0);
        @(negedge clk);
        chk({tag, "/out_valid"}, a_out_valid, 1'b1);
        chk({tag, "/out_data"}, a_out_data, ed);
        chk({tag, "/out_mode"}, a_out_mode, m);
        chk({tag, "/out_adj_err"}, a_out_adj_err, ee);
        @(negedge clk);
        chk({tag, "/done"}, a_out_valid, 1'b0);
    endtask

    task automatic a_reset_pulse(input string tag);
        @(negedge clk);
        a_in_valid = 1'b0; rstn = 1'b0;
        #1 chk({tag, "/in_ready_low"}, a_in_ready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        chk({tag, "/out_valid"}, a_out_valid, 1'b0);
        chk({tag, "/err_cnt"}, a_err_cnt, 16'd0);
    endtask

    initial begin
        logic [7:0] bp_d [8];
        logic [7:0] st_in  [3];
        logic [7:0] st_out [3];
        logic       st_err [3];
        logic [7:0] held;
        int         acc, got;
        logic       take;

        rstn = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_out_ready = 1'b1;
        rnd_in_valid = 1'b0; rnd_in_data = '0; rnd_in_mode = 1'b0; rnd_out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst/in_ready", a_in_ready, 1'b0);
        chk("rst/out_valid", a_out_valid, 1'b0);
        chk("rst/out_data", a_out_data, 8'h00);
        chk("rst/out_adj_err", a_out_adj_err, 1'b0);
        chk("rst/err_cnt", a_err_cnt, 16'd0);
        chk("rst/s1_in_ready", rnd_in_ready[0], 1'b0);
        rstn = 1'b1;

        // Binary -> Gray with exact latency
        a_beat(8'h0B, 1'b0, 8'h0E, 1'b0, "b2g_0B");
        a_beat(8'hFF, 1'b0, 8'h80, 1'b1, "b2g_FF");

        // Gray -> binary streamed back-to-back
        st_in  = '{8'h0E, 8'h80, 8'h00};
        st_out = '{8'h0B, 8'hFF, 8'h00};
        st_err = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_in_valid = (i < 3);
            if (i < 3) begin a_in_data = st_in[i]; a_in_mode = 1'b1; end
            #1;
            if (i < 3) chk("g2b_stream/in_ready", a_in_ready, 1'b1);
            if (i >= 2) begin
                chk("g2b_stream/out_valid", a_out_valid, 1'b1);
                chk("g2b_stream/out_data", a_out_data, st_out[i-2]);
                chk("g2b_stream/out_adj_err", a_out_adj_err, st_err[i-2]);
            end
        end
        @(negedge clk);
        chk("g2b_stream/done", a_out_valid, 1'b0);

        // Adjacency sequence from a clean history
        a_reset_pulse("rst_adj");
        a_beat(8'h00, 1'b1, 8'h00, 1'b0, "adj0");
        a_beat(8'h01, 1'b1, 8'h01, 1'b0, "adj1");
        a_beat(8'h03, 1'b1, 8'h02, 1'b0, "adj2");
        a_beat(8'h00, 1'b1, 8'h00, 1'b1, "adj3");
        a_beat(8'h00, 1'b1, 8'h00, 1'b1, "adj4");
        chk("adj/err_cnt", a_err_cnt, 16'd2);
        a_beat(8'h05, 1'b0, 8'h07, 1'b0, "adj_mode_switch");
        chk("adj/err_cnt_hold", a_err_cnt, 16'd2);

        // Backpressure: fill, hold, then drain in order
        for (int i = 0; i < 8; i++) bp_d[i] = 8'(8'h10 + i);
        a_out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a_in_valid = 1'b1; a_in_data = bp_d[acc & 7]; a_in_mode = 1'b0;
            #1 take = a_in_ready;
            @(posedge clk);
            if (take) acc++;
        end
        @(negedge clk);
        chk("bp/accepted", acc, 2);
        chk("bp/in_ready", a_in_ready, 1'b0);
        chk("bp/out_valid", a_out_valid, 1'b1);
        held = a_out_data;
        chk("bp/head", held, to_gray({8'h00, bp_d[0]}));
        repeat (2) @(negedge clk);
        chk("bp/stable", a_out_data, held);
        a_out_ready = 1'b1;
        a_in_data = bp_d[acc & 7];
        #1 chk("bp/ready_reassert", a_in_ready, 1'b1);
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                a_in_valid = (acc < 3);
                a_in_data  = bp_d[acc & 7];
                #1;
            end
            if (a_out_valid) begin
                chk("bp/order", a_out_data, to_gray({8'h00, bp_d[got & 7]}));
                got++;
            end
            take = a_in_valid && a_in_ready;
            @(posedge clk);
            if (take) acc++;
        end
        chk("bp/delivered", got, 3);
        chk("bp/total_accepted", acc, 3);

        // Reset with two beats in flight
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h20; a_in_mode = 1'b0;
        @(negedge clk);
        a_in_data = 8'h21;
        @(negedge clk);
        chk("midrst/full", a_out_valid, 1'b1);
        a_reset_pulse("midrst");
        #1 chk("midrst/still_empty", a_out_valid, 1'b0);
        a_out_ready = 1'b1;
        a_beat(8'h21, 1'b0, 8'h31, 1'b0, "midrst_first");
        chk("midrst/err_cnt", a_err_cnt, 16'd0);

        // Randomized comparison on the 16-bit instances
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        repeat (200) rnd_cycle(0);
        repeat (600) rnd_cycle(1);
        repeat (12)  rnd_cycle(2);
        chk("s1/drained", wr[0] - rd[0], 0);
        chk("s4/drained", wr[1] - rd[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
